// File: rtl/alu_console_pkg.sv
// Shared opcode table, FSM state encoding and opcode legality check for the ALU console.
package alu_console_pkg;

    localparam int NB_OPCODE = 6;

    localparam logic [NB_OPCODE-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OPCODE-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OPCODE-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OPCODE-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OPCODE-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OPCODE-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OPCODE-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OPCODE-1:0] OP_SRL = 6'b000010;

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'd0,
        ST_LOAD_B  = 2'd1,
        ST_LOAD_OP = 2'd2,
        ST_SHOW    = 2'd3
    } state_e;

    function automatic logic is_legal_op(input logic [NB_OPCODE-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared with the rest of the board design.
module alu
    import alu_console_pkg::*;
#(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 16
) (
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_op)
            OP_ADD:  o_data = i_data_a + i_data_b;
            OP_SUB:  o_data = i_data_a - i_data_b;
            OP_AND:  o_data = i_data_a & i_data_b;
            OP_OR:   o_data = i_data_a | i_data_b;
            OP_XOR:  o_data = i_data_a ^ i_data_b;
            OP_NOR:  o_data = ~(i_data_a | i_data_b);
            OP_SRA:  o_data = $unsigned($signed(i_data_a) >>> i_data_b);
            OP_SRL:  o_data = i_data_a >> i_data_b;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, one-cycle pulse on accepted press.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    logic              sync_0_reg;
    logic              sync_1_reg;
    logic              level_reg;
    logic              pulse_reg;
    logic [NB_CNT-1:0] count_reg;

    // Counter only runs while the synchronised input disagrees with the accepted level,
    // so any glitch back to the old level restarts the count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_0_reg <= 1'b0;
            sync_1_reg <= 1'b0;
            level_reg  <= 1'b0;
            pulse_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            sync_0_reg <= i_btn;
            sync_1_reg <= sync_0_reg;
            pulse_reg  <= 1'b0;
            if (sync_1_reg == level_reg) begin
                count_reg <= '0;
            end else if (count_reg == CNT_LAST) begin
                level_reg <= sync_1_reg;
                pulse_reg <= sync_1_reg;
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign o_pulse = pulse_reg;

endmodule

// File: rtl/alu_console.sv
// Switch/button front-end for the ALU: guided multi-beat operand entry, opcode check, LED display.
module alu_console
    import alu_console_pkg::*;
#(
    parameter int NB_SW           = 8,
    parameter int NB_DATA         = 16,
    parameter int NB_OP           = 6,
    parameter int NB_LEDS         = 16,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic [2:0]         i_btn,
    output logic [NB_LEDS-1:0] o_led,
    output logic [1:0]         o_state,
    output logic               o_zero,
    output logic               o_err
);

    localparam int BEATS   = NB_DATA / NB_SW;
    localparam int NB_BEAT = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [NB_BEAT-1:0] LAST_BEAT = NB_BEAT'(BEATS - 1);

    logic [2:0] btn_pulse;
    logic       enter_pulse;
    logic       back_pulse;
    logic       cancel_pulse;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_btn
            btn_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_btn   (i_btn[gi]),
                .o_pulse (btn_pulse[gi])
            );
        end
    endgenerate

    assign enter_pulse  = btn_pulse[0];
    assign back_pulse   = btn_pulse[1];
    assign cancel_pulse = btn_pulse[2];

    state_e               state_reg,  state_next;
    logic [NB_BEAT-1:0]   beat_reg,   beat_next;
    logic [NB_DATA-1:0]   a_reg,      a_next;
    logic [NB_DATA-1:0]   b_reg,      b_next;
    logic [NB_OP-1:0]     op_reg,     op_next;
    logic [NB_DATA-1:0]   result_reg, result_next;
    logic                 err_reg,    err_next;

    logic [NB_OP-1:0]     sw_op;
    logic [NB_OP-1:0]     alu_op;
    logic [NB_DATA-1:0]   alu_result;

    // While in LOAD_OP the ALU already evaluates the candidate opcode, so the result
    // can be captured on the same edge that latches the opcode.
    assign sw_op  = i_sw[NB_OP-1:0];
    assign alu_op = (state_reg == ST_LOAD_OP) ? sw_op : op_reg;

    alu #(
        .NB_OP   (NB_OP),
        .NB_DATA (NB_DATA)
    ) u_alu (
        .i_data_a (a_reg),
        .i_data_b (b_reg),
        .i_op     (alu_op),
        .o_data   (alu_result)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg  <= ST_LOAD_A;
            beat_reg   <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            beat_reg   <= beat_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        result_next = result_reg;
        err_next    = err_reg;
        if (cancel_pulse) begin
            state_next  = ST_LOAD_A;
            beat_next   = '0;
            a_next      = '0;
            b_next      = '0;
            op_next     = '0;
            result_next = '0;
            err_next    = 1'b0;
        end else if (back_pulse) begin
            beat_next = '0;
            case (state_reg)
                ST_LOAD_B:  state_next = ST_LOAD_A;
                ST_LOAD_OP: state_next = ST_LOAD_B;
                ST_SHOW:    state_next = ST_LOAD_OP;
                default:    state_next = ST_LOAD_A;
            endcase
        end else if (enter_pulse) begin
            case (state_reg)
                ST_LOAD_A, ST_LOAD_B: begin
                    if (state_reg == ST_LOAD_A) a_next[beat_reg*NB_SW +: NB_SW] = i_sw;
                    else                        b_next[beat_reg*NB_SW +: NB_SW] = i_sw;
                    if (beat_reg == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = (state_reg == ST_LOAD_A) ? ST_LOAD_B : ST_LOAD_OP;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
                ST_LOAD_OP: begin
                    if (is_legal_op(sw_op)) begin
                        op_next     = sw_op;
                        result_next = alu_result;
                        err_next    = 1'b0;
                        state_next  = ST_SHOW;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_LOAD_A;
                    beat_next  = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_led   = '0;
        o_state = state_reg;
        o_err   = err_reg;
        o_zero  = (state_reg == ST_SHOW) && (result_reg == '0);
        case (state_reg)
            ST_LOAD_A:  o_led = NB_LEDS'(a_reg);
            ST_LOAD_B:  o_led = NB_LEDS'(b_reg);
            ST_LOAD_OP: o_led = NB_LEDS'(op_reg);
            default:    o_led = NB_LEDS'(result_reg);
        endcase
    end

endmodule
